// File: rtl/fridge_compressor_scheduler.sv
// Compressor / defrost sequencer with short-cycle protection and a door-open alarm.
// Define FRIDGE_DOOR_ALARM_EN to build the door-alarm counter; otherwise door_alarm is tied to 0.
module fridge_compressor_scheduler #(
  parameter int CNT_W            = 16,
  parameter int MIN_ON           = 4,
  parameter int MIN_OFF          = 3,
  parameter int DEFROST_INTERVAL = 10,
  parameter int DEFROST_TIME     = 5,
  parameter int DOOR_ALARM       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cool_req,
  input  logic       door_open,
  output logic       compressor_on,
  output logic       defrost_on,
  output logic       door_alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    OFF_HOLD = 2'd2,
    DEFROST  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] MIN_ON_M1       = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_M1      = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] DEFROST_TIME_M1 = CNT_W'(DEFROST_TIME - 1);
  localparam logic [CNT_W-1:0] ACC_MAX         = CNT_W'(DEFROST_INTERVAL);
  localparam logic [CNT_W-1:0] ACC_TRIG        = CNT_W'(DEFROST_INTERVAL - 1);

  if (MIN_ON < 1 || MIN_OFF < 1 || DEFROST_INTERVAL < MIN_ON ||
      DEFROST_TIME < 1 || DOOR_ALARM < 1) begin : g_bad_params
    $error("fridge_compressor_scheduler: illegal parameter combination");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             door_meta_q, door_meta_d;
  logic             door_s_q, door_s_d;
  logic             exit_ok;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    door_meta_d = door_open;
    door_s_d    = door_meta_q;
    state_d     = state_q;
    exit_ok     = (timer_q >= MIN_ON_M1);

    unique case (state_q)
      IDLE: begin
        // A request while the door is open is simply ignored, not remembered.
        if (cool_req && !door_s_q) state_d = RUN;
      end
      RUN: begin
        if (exit_ok && (acc_q >= ACC_TRIG))          state_d = DEFROST;
        else if (exit_ok && (!cool_req || door_s_q)) state_d = OFF_HOLD;
      end
      OFF_HOLD: begin
        if (timer_q == MIN_OFF_M1) state_d = IDLE;
      end
      DEFROST: begin
        if (timer_q == DEFROST_TIME_M1) state_d = OFF_HOLD;
      end
      default: state_d = OFF_HOLD;
    endcase

    if (state_d != state_q)  timer_d = '0;
    else if (timer_q != '1)  timer_d = timer_q + CNT_W'(1);
    else                     timer_d = timer_q;

    acc_d = acc_q;
    if ((state_q == RUN) && (acc_q < ACC_MAX)) acc_d = acc_q + CNT_W'(1);
    if ((state_q == DEFROST) && (state_d == OFF_HOLD)) acc_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // Reset lands in OFF_HOLD so the minimum off-time also holds after any reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= OFF_HOLD;
      timer_q     <= '0;
      acc_q       <= '0;
      door_meta_q <= 1'b0;
      door_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      acc_q       <= acc_d;
      door_meta_q <= door_meta_d;
      door_s_q    <= door_s_d;
    end
  end

  assign state         = state_q;
  assign compressor_on = (state_q == RUN);
  assign defrost_on    = (state_q == DEFROST);

`ifdef FRIDGE_DOOR_ALARM_EN
  localparam int AW = $clog2(DOOR_ALARM + 1);
  localparam logic [AW-1:0] ALARM_MAX = AW'(DOOR_ALARM);

  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic          door_alarm_q, door_alarm_d;

  always_comb begin
    alarm_cnt_d = alarm_cnt_q;
    if (!door_s_q)                    alarm_cnt_d = '0;
    else if (alarm_cnt_q != ALARM_MAX) alarm_cnt_d = alarm_cnt_q + AW'(1);
    door_alarm_d = (alarm_cnt_d == ALARM_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_cnt_q  <= '0;
      door_alarm_q <= 1'b0;
    end else begin
      alarm_cnt_q  <= alarm_cnt_d;
      door_alarm_q <= door_alarm_d;
    end
  end

  assign door_alarm = door_alarm_q;
`else
  assign door_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_fridge_compressor_scheduler.sv
// Table-driven bench for fridge_compressor_scheduler at default parameters,
// plus hand-written power-on and mid-run reset sequences.
module tb_fridge_compressor_scheduler;

  logic       clk;
  logic       reset;
  logic       cool_req;
  logic       door_open;
  logic       compressor_on;
  logic       defrost_on;
  logic       door_alarm;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       cool;
    logic       door;
    logic [1:0] exp_state;
    logic       exp_alarm;  // value when the alarm feature is built
  } vec_t;

  vec_t vecs[$];

  fridge_compressor_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .cool_req     (cool_req),
    .door_open    (door_open),
    .compressor_on(compressor_on),
    .defrost_on   (defrost_on),
    .door_alarm   (door_alarm),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int idx, input logic [1:0] act,
                       input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step=%0d actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [1:0] exp_st,
                           input logic exp_al_en);
    logic exp_al;
`ifdef FRIDGE_DOOR_ALARM_EN
    exp_al = exp_al_en;
`else
    exp_al = 1'b0;
    if (exp_al_en) exp_al = 1'b0;
`endif
    check({tag, ".state"}, idx, state, exp_st);
    check({tag, ".compressor_on"}, idx, {1'b0, compressor_on}, {1'b0, exp_st == 2'd1});
    check({tag, ".defrost_on"}, idx, {1'b0, defrost_on}, {1'b0, exp_st == 2'd3});
    check({tag, ".door_alarm"}, idx, {1'b0, door_alarm}, {1'b0, exp_al});
  endtask

  function automatic void add(input int n, input logic c, input logic d,
                              input logic [1:0] st, input logic al);
    for (int i = 0; i < n; i++) vecs.push_back('{cool: c, door: d, exp_state: st, exp_alarm: al});
  endfunction

  // Drive inputs away from the edge, then sample 1 time unit after the edge.
  task automatic step(input logic c, input logic d);
    cool_req  = c;
    door_open = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each entry: inputs before edge k, expected outputs after edge k (k counts from reset release).
    add(2,  1, 0, 2'd2, 0);  // power-up off-hold
    add(1,  1, 0, 2'd0, 0);  // single IDLE cycle
    add(10, 1, 0, 2'd1, 0);  // edges 4..13: run until accumulator trips
    add(5,  1, 0, 2'd3, 0);  // edges 14..18: defrost
    add(3,  1, 0, 2'd2, 0);  // edges 19..21: off-hold ignores cool_req
    add(1,  1, 0, 2'd0, 0);  // edge 22
    add(6,  1, 0, 2'd1, 0);  // edges 23..28: fresh accumulator, run cycles 1..6
    add(2,  1, 1, 2'd1, 0);  // edges 29..30: door opens, still synchronizing
    add(3,  1, 1, 2'd2, 0);  // edges 31..33: door drops compressor 3 edges after open
    add(2,  1, 1, 2'd0, 0);  // edges 34..35: request held off by open door
    add(3,  1, 1, 2'd0, 1);  // edges 36..38: alarm 8 edges after door_open
    add(2,  1, 0, 2'd0, 1);  // edges 39..40: door closing, door_s still high
    add(4,  1, 0, 2'd1, 0);  // edges 41..44: alarm clears, minimum-on run
    add(5,  1, 0, 2'd3, 0);  // edges 45..49: defrost has priority over continuing
    add(3,  1, 0, 2'd2, 0);  // edges 50..52
    add(1,  1, 0, 2'd0, 0);  // edge 53

    reset     = 1'b1;
    cool_req  = 1'b0;
    door_open = 1'b0;
    #2;
    check_all("reset_async", 0, 2'd2, 0);
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_held", 0, 2'd2, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].cool, vecs[i].door);
      check_all("vec", i + 1, vecs[i].exp_state, vecs[i].exp_alarm);
    end

    // Short-pulse run: a one-cycle request still yields exactly MIN_ON cycles of compressor.
    step(1, 0); check_all("pulse", 1, 2'd1, 0);
    for (int k = 2; k <= 4; k++) begin
      step(0, 0); check_all("pulse", k, 2'd1, 0);
    end
    for (int k = 5; k <= 7; k++) begin
      step(0, 0); check_all("pulse", k, 2'd2, 0);
    end
    step(0, 0); check_all("pulse", 8, 2'd0, 0);

    // Mid-run reset: assert during the second RUN cycle, outputs must drop without a clock edge.
    step(1, 0); check_all("midrst", 1, 2'd1, 0);
    step(1, 0); check_all("midrst", 2, 2'd1, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all("midrst_async", 3, 2'd2, 0);
    @(posedge clk);
    #1;
    check_all("midrst_held", 4, 2'd2, 0);
    reset = 1'b0;
    step(1, 0); check_all("midrst_rel", 1, 2'd2, 0);
    step(1, 0); check_all("midrst_rel", 2, 2'd2, 0);
    step(1, 0); check_all("midrst_rel", 3, 2'd0, 0);
    step(1, 0); check_all("midrst_rel", 4, 2'd1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
